regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter N, default 16: register data width in bits.
REQ-002 Parameter NREQ, default 4: number of write requesters.
REQ-003 Parameter NREG, default 8: number of registers in the file.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be as follows:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester write request
- req_reg  in  NREQ x 3  per-requester destination register index
- req_data  in  NREQ x N  per-requester write data
- clear_start  in  1  one-cycle pulse that starts a sequenced clear of all registers
- gnt  out  NREQ  one-hot grant, combinational in the same cycle as req
- ld  out  NREG  one-hot register load_enable, registered
- clr  out  NREG  one-hot register clear, registered
- bus_data  out  N  write data to the register file, registered
- busy  out  1  high while a clear sequence runs

Function
REQ-006 Handshake: a write transfers on a rising edge where req[i] and gnt[i] are both high; a requester SHALL hold req, req_reg and req_data stable until that edge.
REQ-007 At most one gnt bit SHALL be high per cycle; gnt SHALL be 0 when req is 0, in CLEAR, or when clear_start is high.
REQ-008 Round-robin priority: search starts at pointer ptr and ascends modulo NREQ; the first requester with req high wins.
REQ-009 After a transfer to requester i, ptr SHALL become (i+1) mod NREQ (NREQ-1 wraps to 0); ptr SHALL be unchanged in cycles with no transfer.
REQ-010 Latency: after a transfer at edge k, ld[req_reg[i]]=1 and bus_data=req_data[i] SHALL hold in cycle k..k+1, so the register captures the data at edge k+1.
REQ-011 ld SHALL be all-zero in every cycle not following a transfer; bus_data SHALL retain its last value.
REQ-012 The FSM SHALL have two states, IDLE and CLEAR.
REQ-013 IDLE to CLEAR: clear_start high in IDLE; the counter cnt loads 0.
REQ-014 In CLEAR, clr SHALL be one-hot at index cnt in the following cycle; cnt increments each cycle, so registers 0..NREG-1 are cleared in order over NREG cycles.
REQ-015 CLEAR to IDLE: on the edge where cnt = NREG-1; busy SHALL be high exactly NREG cycles.
REQ-016 If clear_start and req are high in the same IDLE cycle, clear wins: no grant, and ptr is unchanged.
REQ-017 clear_start in CLEAR SHALL be ignored (no restart, no extension).
REQ-018 Requests pending during CLEAR SHALL be held off; arbitration resumes in the first IDLE cycle with ptr as before the clear.
REQ-019 ld and clr SHALL never be nonzero in the same cycle.
REQ-020 A requester may present a new request in the cycle after its transfer; if it is the only requester, it SHALL be granted again.

Reset
REQ-021 Reset_n low SHALL immediately force: state=IDLE, ptr=0, cnt=0, ld=0, clr=0, bus_data=0, busy=0.
REQ-022 Reset asserted mid-CLEAR SHALL abort the sequence; registers not yet cleared are left untouched by this block.
REQ-023 A write whose ld cycle is cut by reset SHALL be lost; no replay.

Structure
REQ-024 A shared package regarb_pkg SHALL hold the state enum (IDLE, CLEAR) and the default constants for N, NREQ and NREG.
REQ-025 Round-robin selection SHALL be a combinational sub-module, rr_arbiter (inputs req and ptr; output one-hot gnt).
REQ-026 All sequential state SHALL live in regfile_write_arbiter.

Verification
REQ-027 Single write: req=0001, req_reg[0]=3, req_data[0]=16'hBEEF -> gnt=0001 in the same cycle; next cycle ld=8'h08 and bus_data=BEEF; ld=0 after.
REQ-028 Contention: req=1111 held, each requester deasserting after its grant -> grants in order 0,1,2,3; ptr wraps to 0.
REQ-029 Wrap: ptr=3, req=1001 -> gnt=1000, then gnt=0001.
REQ-030 Clear: clear_start pulse with req=0010 in the same cycle -> gnt=0 and busy=1 for 8 cycles; clr walks 01,02,...,80; requester 1 is granted in the first IDLE cycle.
REQ-031 Reset mid-clear: Reset_n low at cnt=4 -> all outputs 0 immediately; after release, IDLE and ptr=0.
REQ-032 Throughout all scenarios: gnt and ld are one-hot or zero, and ld and clr are never both nonzero.

Source files
------------

// File: rtl/regarb_pkg.sv
// +--------------------------------------------------------------------+
// | regarb_pkg : shared types and default sizes for the register-file  |
// | write arbiter.                          Revision: 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

package regarb_pkg;

  localparam int DEF_N     = 16;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_NREG  = 8;
  // Destination index width carried on each requester's req_reg lane.
  localparam int REG_IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, searching upward from |
// | ptr modulo NREQ.                        Revision: 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// +--------------------------------------------------------------------+
// | regfile_write_arbiter : round-robin write port arbiter with a      |
// | sequenced clear of the whole register file. Revision: 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ,
  parameter int NREG = DEF_NREG
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*REG_IDX_W-1:0] req_reg,
  input  logic [NREQ*N-1:0]         req_data,
  input  logic                      clear_start,
  output logic [NREQ-1:0]           gnt,
  output logic [NREG-1:0]           ld,
  output logic [NREG-1:0]           clr,
  output logic [N-1:0]              bus_data,
  output logic                      busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PW-1:0]          r_ptr;
  logic [CW-1:0]          r_cnt;
  logic [NREG-1:0]        r_ld;
  logic [NREG-1:0]        r_clr;
  logic [N-1:0]           r_bus;

  logic                   w_arb_en;
  logic                   w_xfer;
  logic [NREQ-1:0]        w_rr_gnt;
  logic [NREQ-1:0]        w_gnt;
  logic [PW-1:0]          w_gidx;
  logic [PW-1:0]          w_ptr_nxt;
  logic [REG_IDX_W-1:0]   w_sel_reg;
  logic [N-1:0]           w_sel_data;
  logic [NREG-1:0]        w_ld_dec;
  logic [NREG-1:0]        w_clr_dec;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req  (req),
    .ptr  (r_ptr),
    .gnt  (w_rr_gnt)
  );

  // Arbitration is only open in IDLE and yields to a same-cycle clear request.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_start) w_state_nxt = CLEAR;
        else             w_arb_en    = 1'b1;
      end
      CLEAR: begin
        if (r_cnt == CW'(NREG - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_gnt  = w_arb_en ? w_rr_gnt : '0;
  assign w_xfer = |w_gnt;

  always_comb begin
    w_gidx     = '0;
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gidx     = PW'(i);
        w_sel_reg  = req_reg[i*REG_IDX_W +: REG_IDX_W];
        w_sel_data = req_data[i*N +: N];
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);

  always_comb begin
    w_ld_dec  = '0;
    w_clr_dec = '0;
    for (int r = 0; r < NREG; r++) begin
      w_ld_dec[r]  = (w_sel_reg == REG_IDX_W'(r));
      w_clr_dec[r] = (r_cnt == CW'(r));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // clr lags cnt by one cycle, so the last strobe lands in the first IDLE
  // cycle; any grant there produces ld one cycle later, keeping them disjoint.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ld  <= '0;
      r_clr <= '0;
      r_bus <= '0;
    end else begin
      r_ld <= w_xfer ? w_ld_dec : '0;
      if (w_xfer) begin
        r_bus <= w_sel_data;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == IDLE) begin
        r_clr <= '0;
        if (clear_start) r_cnt <= '0;
      end else begin
        r_clr <= w_clr_dec;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign gnt      = w_gnt;
  assign ld       = r_ld;
  assign clr      = r_clr;
  assign bus_data = r_bus;
  assign busy     = (r_state == CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_regfile_write_arbiter : directed self-checking bench for the    |
// | register-file write arbiter.            Revision: 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [11:0] req_reg;
  logic [63:0] req_data;
  logic        clear_start;
  logic [3:0]  gnt;
  logic [7:0]  ld;
  logic [7:0]  clr;
  logic [15:0] bus_data;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit r_run_inv = 1'b0;

  regfile_write_arbiter #(
    .N    (16),
    .NREQ (4),
    .NREG (8)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req         (req),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .clear_start (clear_start),
    .gnt         (gnt),
    .ld          (ld),
    .clr         (clr),
    .bus_data    (bus_data),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic [2:0] r, input logic [15:0] d);
    req_reg[i*3 +: 3]    = r;
    req_data[i*16 +: 16] = d;
  endtask

  // gnt/ld one-hot-or-zero and ld/clr mutually exclusive in every cycle.
  always @(negedge Clk) begin
    if (r_run_inv)
      check("invariant", {29'd0, $onehot0(gnt), $onehot0(ld), !((|ld) && (|clr))}, 32'd7);
  end

  initial begin
    Reset_n     = 1'b0;
    req         = '0;
    req_reg     = '0;
    req_data    = '0;
    clear_start = 1'b0;
    #1;
    check("rst_ld",   ld,       0);
    check("rst_clr",  clr,      0);
    check("rst_bus",  bus_data, 0);
    check("rst_busy", busy,     0);
    check("rst_gnt",  gnt,      0);
    @(negedge Clk);
    Reset_n   = 1'b1;
    r_run_inv = 1'b1;
    tick();

    // Single write
    set_rq(0, 3'd3, 16'hBEEF);
    req = 4'b0001;
    #1 check("single_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    #1;
    check("single_ld",  ld,       8'h08);
    check("single_bus", bus_data, 16'hBEEF);
    check("single_gnt_off", gnt,  0);
    tick();
    check("single_ld_off", ld,       0);
    check("single_bus_hold", bus_data, 16'hBEEF);

    // Requester 3 moves ptr from 1 back to 0
    set_rq(3, 3'd5, 16'h1234);
    req = 4'b1000;
    #1 check("r3_gnt", gnt, 4'b1000);
    tick();
    req = 4'b0000;
    #1;
    check("r3_ld",  ld,       8'h20);
    check("r3_bus", bus_data, 16'h1234);

    // Contention: all four requesting, each drops after its grant
    for (int k = 0; k < 4; k++) set_rq(k, 3'(k), 16'hA000 + 16'(k));
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1 check("cont_gnt", gnt, 32'(1) << k);
      tick();
      req[k] = 1'b0;
      #1;
      check("cont_ld",  ld,       32'(1) << k);
      check("cont_bus", bus_data, 32'(16'hA000 + 16'(k)));
    end
    req = 4'b1001;
    #1 check("ptr_wrapped_to_0", gnt, 4'b0001);
    req = 4'b0000;

    // Wrap: move ptr to 3, then 1001 -> 1000 then 0001
    tick();
    req = 4'b0100;
    #1 check("p2_gnt", gnt, 4'b0100);
    tick();
    req = 4'b1001;
    #1 check("wrap_gnt3", gnt, 4'b1000);
    tick();
    req = 4'b0001;
    #1;
    check("wrap_ld3",  ld,       8'h08);
    check("wrap_bus3", bus_data, 16'hA003);
    check("wrap_gnt0", gnt,      4'b0001);
    tick();
    req = 4'b0000;
    #1;
    check("wrap_ld0",  ld,       8'h01);
    check("wrap_bus0", bus_data, 16'hA000);

    // Back-to-back grant to a lone requester
    set_rq(0, 3'd2, 16'h1111);
    req = 4'b0001;
    #1 check("b2b_gnt_a", gnt, 4'b0001);
    tick();
    set_rq(0, 3'd6, 16'h2222);
    #1;
    check("b2b_gnt_b", gnt,      4'b0001);
    check("b2b_ld_a",  ld,       8'h04);
    check("b2b_bus_a", bus_data, 16'h1111);
    tick();
    req = 4'b0000;
    #1;
    check("b2b_ld_b",  ld,       8'h40);
    check("b2b_bus_b", bus_data, 16'h2222);

    // Clear wins over a same-cycle request; ptr stays at 1
    set_rq(0, 3'd0, 16'hA000);
    req         = 4'b0011;
    clear_start = 1'b1;
    #1 check("clr_vs_req_gnt", gnt, 0);
    tick();
    clear_start = 1'b0;
    #1;
    check("clr_c0_busy", busy, 1);
    check("clr_c0_clr",  clr,  0);
    check("clr_c0_gnt",  gnt,  0);
    check("clr_c0_ld",   ld,   0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("clr_walk", clr, 32'(1) << (k - 1));
      check("clr_busy", busy, (k < 8) ? 32'd1 : 32'd0);
      check("clr_gnt",  gnt,  (k < 8) ? 32'd0 : 32'd2);
      clear_start = (k == 3);
    end
    tick();
    req = 4'b0000;
    #1;
    check("post_clr_ld",  ld,       8'h02);
    check("post_clr_bus", bus_data, 16'hA001);
    check("post_clr_clr", clr,      0);

    // Reset in the middle of a clear (ptr is 2 here)
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (4) tick();
    check("pre_rst_clr",  clr,  8'h08);
    check("pre_rst_busy", busy, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy,     0);
    check("mid_rst_clr",  clr,      0);
    check("mid_rst_ld",   ld,       0);
    check("mid_rst_bus",  bus_data, 0);
    check("mid_rst_gnt",  gnt,      0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_clr",  clr,  0);
    req = 4'b1111;
    #1 check("post_rst_ptr0", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    r_run_inv = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
